// File: rtl/v_table_ctrl_if.sv
// Write-port bundle for the context-state table controller: update pipe,
// flush handshake, reinit request and the registered table/status outputs.
interface v_table_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned W  = 64
);
  logic          i_upd_wen;
  logic [AW-1:0] i_upd_waddr;
  logic [W-1:0]  i_upd_wdata;
  logic          i_flush_req;
  logic [AW-1:0] i_flush_addr;
  logic          o_flush_ack_r;
  logic          i_reinit;
  logic          o_upd_hold_r;
  logic          o_wen_r;
  logic [AW-1:0] o_waddr_r;
  logic [W-1:0]  o_wdata_r;
  logic          o_busy_r;
  logic [7:0]    o_drop_cnt_r;

  // Requester side: update pipe, flush client and reinit source.
  modport master (
    output i_upd_wen, i_upd_waddr, i_upd_wdata,
    output i_flush_req, i_flush_addr, i_reinit,
    input  o_flush_ack_r, o_upd_hold_r, o_wen_r, o_waddr_r, o_wdata_r,
    input  o_busy_r, o_drop_cnt_r
  );

  // Controller side.
  modport slave (
    input  i_upd_wen, i_upd_waddr, i_upd_wdata,
    input  i_flush_req, i_flush_addr, i_reinit,
    output o_flush_ack_r, o_upd_hold_r, o_wen_r, o_waddr_r, o_wdata_r,
    output o_busy_r, o_drop_cnt_r
  );
endinterface

// File: rtl/v_table_ctrl.sv
// Context-state table write-port owner: init sweep after reset/reinit, then
// fixed-priority arbitration of update writes over single-context flushes,
// with a starvation throttle on the update front-end.
module v_table_ctrl #(
  parameter int unsigned       N          = 256,
  parameter int unsigned       W          = 64,
  parameter logic [W-1:0]      INIT_VAL   = '0,
  parameter int unsigned       STARVE_MAX = 15,
  localparam int unsigned      AW         = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  v_table_ctrl_if.slave     bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] ctr, ctr_n;
  logic [7:0]    wait_ctr, wait_n;
  logic          lock, lock_n;     // flush acked, waiting for req to go low
  logic          swept, swept_n;   // pending flush already covered by a sweep
  logic          wen_n, ack_n, busy_n, hold_n;
  logic [AW-1:0] waddr_n;
  logic [W-1:0]  wdata_n;
  logic [7:0]    drop_n;
  logic          pending;

  assign pending = bus.i_flush_req && !lock;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_INIT;
      ctr               <= '0;
      wait_ctr          <= '0;
      lock              <= 1'b0;
      swept             <= 1'b0;
      bus.o_wen_r       <= 1'b0;
      bus.o_waddr_r     <= '0;
      bus.o_wdata_r     <= '0;
      bus.o_flush_ack_r <= 1'b0;
      bus.o_busy_r      <= 1'b1;
      bus.o_upd_hold_r  <= 1'b0;
      bus.o_drop_cnt_r  <= '0;
    end else begin
      state             <= state_n;
      ctr               <= ctr_n;
      wait_ctr          <= wait_n;
      lock              <= lock_n;
      swept             <= swept_n;
      bus.o_wen_r       <= wen_n;
      bus.o_waddr_r     <= waddr_n;
      bus.o_wdata_r     <= wdata_n;
      bus.o_flush_ack_r <= ack_n;
      bus.o_busy_r      <= busy_n;
      bus.o_upd_hold_r  <= hold_n;
      bus.o_drop_cnt_r  <= drop_n;
    end
  end

  // Next-state: sweep sequencing, write arbitration, starvation tracking.
  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    wait_n  = wait_ctr;
    lock_n  = bus.i_flush_req ? lock : 1'b0;
    swept_n = swept;
    wen_n   = 1'b0;
    waddr_n = '0;
    wdata_n = '0;
    ack_n   = 1'b0;
    busy_n  = 1'b0;
    drop_n  = bus.o_drop_cnt_r;

    if (bus.i_reinit) begin
      state_n = ST_INIT;
      ctr_n   = '0;
      busy_n  = 1'b1;
      wait_n  = '0;
      if (bus.i_upd_wen && drop_n != 8'hFF) drop_n = drop_n + 8'd1;
      if (pending) swept_n = 1'b1;
    end else begin
      unique case (state)
        ST_INIT: begin
          busy_n  = 1'b1;
          wen_n   = 1'b1;
          waddr_n = ctr;
          wdata_n = INIT_VAL;
          wait_n  = '0;
          if (ctr == AW'(N - 1)) begin
            state_n = ST_RUN;
            ctr_n   = '0;
          end else begin
            ctr_n = ctr + 1'b1;
          end
          if (bus.i_upd_wen && drop_n != 8'hFF) drop_n = drop_n + 8'd1;
          if (pending) swept_n = 1'b1;
        end
        ST_RUN: begin
          // A flush that was pending across a sweep is acked without a write;
          // the update pipe still gets the port in that cycle.
          if (pending && swept) begin
            ack_n   = 1'b1;
            lock_n  = 1'b1;
            swept_n = 1'b0;
            wait_n  = '0;
          end
          if (bus.i_upd_wen) begin
            wen_n   = 1'b1;
            waddr_n = bus.i_upd_waddr;
            wdata_n = bus.i_upd_wdata;
            if (pending && !swept && wait_ctr != 8'(STARVE_MAX))
              wait_n = wait_ctr + 8'd1;
          end else if (pending && !swept) begin
            wen_n   = 1'b1;
            waddr_n = bus.i_flush_addr;
            wdata_n = INIT_VAL;
            ack_n   = 1'b1;
            lock_n  = 1'b1;
            wait_n  = '0;
          end
        end
        default: state_n = ST_INIT;
      endcase
    end

    hold_n = (wait_n == 8'(STARVE_MAX));
  end

endmodule

// File: tb/tb_v_table_ctrl.sv
// Directed bench for v_table_ctrl with N=8, STARVE_MAX=4, nonzero INIT_VAL.
module tb_v_table_ctrl;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned W  = 16;
  localparam logic [W-1:0] IV = 16'h5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  v_table_ctrl_if #(.AW(AW), .W(W)) bus ();

  v_table_ctrl #(.N(N), .W(W), .INIT_VAL(IV), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic wen, input logic [AW-1:0] a,
                        input logic [W-1:0] d);
    chk({tag, ".wen"}, 64'(bus.o_wen_r), 64'(wen));
    if (wen) begin
      chk({tag, ".addr"}, 64'(bus.o_waddr_r), 64'(a));
      chk({tag, ".data"}, 64'(bus.o_wdata_r), 64'(d));
    end
  endtask

  initial begin
    bus.i_upd_wen    = 1'b0;
    bus.i_upd_waddr  = '0;
    bus.i_upd_wdata  = '0;
    bus.i_flush_req  = 1'b0;
    bus.i_flush_addr = '0;
    bus.i_reinit     = 1'b0;

    // Reset values.
    repeat (2) step();
    chk("rst.busy", 64'(bus.o_busy_r), 64'd1);
    chk("rst.wen", 64'(bus.o_wen_r), 64'd0);
    chk("rst.ack", 64'(bus.o_flush_ack_r), 64'd0);
    chk("rst.hold", 64'(bus.o_upd_hold_r), 64'd0);
    chk("rst.drop", 64'(bus.o_drop_cnt_r), 64'd0);
    rst_n = 1'b1;

    // Sweep: addr 0..7 on cycles 1..8, busy low from cycle 9.
    for (int k = 0; k < N; k++) begin
      step();
      chk_wr("sweep", 1'b1, AW'(k), IV);
      chk("sweep.busy", 64'(bus.o_busy_r), 64'd1);
    end
    step();
    chk("run.busy", 64'(bus.o_busy_r), 64'd0);
    chk("run.wen", 64'(bus.o_wen_r), 64'd0);

    // Update forwarded next cycle, no ack.
    bus.i_upd_wen = 1'b1; bus.i_upd_waddr = 3'd5; bus.i_upd_wdata = 16'h00AB;
    step();
    bus.i_upd_wen = 1'b0;
    chk_wr("upd", 1'b1, 3'd5, 16'h00AB);
    chk("upd.ack", 64'(bus.o_flush_ack_r), 64'd0);

    // Flush addr 3: write + ack next cycle; req held one more cycle, no rewrite.
    bus.i_flush_req = 1'b1; bus.i_flush_addr = 3'd3;
    step();
    chk_wr("fl", 1'b1, 3'd3, IV);
    chk("fl.ack", 64'(bus.o_flush_ack_r), 64'd1);
    step();
    bus.i_flush_req = 1'b0;
    chk("fl.held.wen", 64'(bus.o_wen_r), 64'd0);
    chk("fl.held.ack", 64'(bus.o_flush_ack_r), 64'd0);
    step();
    chk("fl.low.wen", 64'(bus.o_wen_r), 64'd0);

    // Same-address collision: update wins, flush follows.
    bus.i_upd_wen = 1'b1; bus.i_upd_waddr = 3'd2; bus.i_upd_wdata = 16'h0077;
    bus.i_flush_req = 1'b1; bus.i_flush_addr = 3'd2;
    step();
    bus.i_upd_wen = 1'b0;
    chk_wr("col.upd", 1'b1, 3'd2, 16'h0077);
    chk("col.ack0", 64'(bus.o_flush_ack_r), 64'd0);
    step();
    chk_wr("col.fl", 1'b1, 3'd2, IV);
    chk("col.ack1", 64'(bus.o_flush_ack_r), 64'd1);
    bus.i_flush_req = 1'b0;
    step();

    // Starvation: updates every cycle; hold after 4 waits.
    bus.i_flush_req = 1'b1; bus.i_flush_addr = 3'd6;
    bus.i_upd_wen = 1'b1; bus.i_upd_waddr = 3'd1;
    for (int k = 1; k <= 5; k++) begin
      bus.i_upd_wdata = 16'(k);
      step();
      chk_wr("stv.upd", 1'b1, 3'd1, 16'(k));
      chk("stv.ack", 64'(bus.o_flush_ack_r), 64'd0);
      chk("stv.hold", 64'(bus.o_upd_hold_r), (k >= 4) ? 64'd1 : 64'd0);
    end
    bus.i_upd_wen = 1'b0;
    step();
    chk_wr("stv.fl", 1'b1, 3'd6, IV);
    chk("stv.ack1", 64'(bus.o_flush_ack_r), 64'd1);
    chk("stv.hold0", 64'(bus.o_upd_hold_r), 64'd0);
    bus.i_flush_req = 1'b0;
    step();

    // Reinit with pending flush and coincident update.
    bus.i_flush_req = 1'b1; bus.i_flush_addr = 3'd4;
    bus.i_upd_wen = 1'b1; bus.i_upd_waddr = 3'd0; bus.i_upd_wdata = 16'h1111;
    bus.i_reinit = 1'b1;
    step();
    bus.i_reinit = 1'b0; bus.i_upd_wen = 1'b0;
    chk("ri.wen", 64'(bus.o_wen_r), 64'd0);
    chk("ri.busy", 64'(bus.o_busy_r), 64'd1);
    chk("ri.drop", 64'(bus.o_drop_cnt_r), 64'd1);
    for (int k = 0; k < N; k++) begin
      step();
      chk_wr("ri.sweep", 1'b1, AW'(k), IV);
      chk("ri.sweep.ack", 64'(bus.o_flush_ack_r), 64'd0);
    end
    step();
    chk("ri.run.busy", 64'(bus.o_busy_r), 64'd0);
    chk("ri.run.ack", 64'(bus.o_flush_ack_r), 64'd1);
    chk("ri.run.wen", 64'(bus.o_wen_r), 64'd0);
    bus.i_flush_req = 1'b0;
    step();
    chk("ri.after.ack", 64'(bus.o_flush_ack_r), 64'd0);

    // Drop counter saturation: 300 updates while reinit keeps the table busy.
    bus.i_reinit = 1'b1; bus.i_upd_wen = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (k == 2) chk("drop.4", 64'(bus.o_drop_cnt_r), 64'd4);
    end
    chk("drop.sat", 64'(bus.o_drop_cnt_r), 64'd255);
    bus.i_reinit = 1'b0; bus.i_upd_wen = 1'b0;

    // Reset mid-sweep at ctr=4, with a flush pending: no ack, restart at 0.
    bus.i_flush_req = 1'b1; bus.i_flush_addr = 3'd7;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_wr("ms.sweep", 1'b1, AW'(k), IV);
    end
    rst_n = 1'b0;
    #2;
    chk("ms.rst.wen", 64'(bus.o_wen_r), 64'd0);
    chk("ms.rst.busy", 64'(bus.o_busy_r), 64'd1);
    chk("ms.rst.drop", 64'(bus.o_drop_cnt_r), 64'd0);
    chk("ms.rst.addr", 64'(bus.o_waddr_r), 64'd0);
    bus.i_flush_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      step();
      chk_wr("ms.resweep", 1'b1, AW'(k), IV);
      chk("ms.resweep.ack", 64'(bus.o_flush_ack_r), 64'd0);
    end
    step();
    chk("ms.run.busy", 64'(bus.o_busy_r), 64'd0);
    chk("ms.run.ack", 64'(bus.o_flush_ack_r), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
